lfsr_scrambler_par: RTL and testbench

Parametrised, registered successor to the fixed 64/411-bit dual-LFSR scrambler. The block has two linear-feedback shift registers, both with configurable width and tap mask. It advances them STEPS bit-steps per accepted input word and presents the data-LFSR state on a valid/ready output stage. It sits between the serial-bit source and the downstream framer and adds seed loading, back-pressure, a block limit and optional zero-seed protection.

---
 rtl/lfsr_scr_pkg.sv | 31 +++
 rtl/lfsr_scr_step.sv | 30 +++
 rtl/lfsr_scrambler_par.sv | 138 +++++++++++++
 tb/tb_lfsr_scrambler_par.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_scr_pkg.sv
// Shared types and default constants for the parametrised dual-LFSR scrambler.
// Tap masks list the feedback positions; bit 0 of each mask is never used.
package lfsr_scr_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_AUX_W  = 411;
    localparam int DEF_STEPS  = 7;
    localparam int DEF_CNT_W  = 16;

    localparam logic [DEF_DATA_W-1:0] DEF_DATA_TAPS =
        (64'd1 <<  1) | (64'd1 <<  6) | (64'd1 <<  8) | (64'd1 <<  9) |
        (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 16) | (64'd1 << 17) |
        (64'd1 << 18) | (64'd1 << 23) | (64'd1 << 24) | (64'd1 << 25) |
        (64'd1 << 26) | (64'd1 << 28) | (64'd1 << 30) | (64'd1 << 31) |
        (64'd1 << 32) | (64'd1 << 34) | (64'd1 << 36) | (64'd1 << 39) |
        (64'd1 << 40) | (64'd1 << 41) | (64'd1 << 42) | (64'd1 << 44) |
        (64'd1 << 46) | (64'd1 << 50) | (64'd1 << 51) | (64'd1 << 53) |
        (64'd1 << 54) | (64'd1 << 56) | (64'd1 << 59) | (64'd1 << 62) |
        (64'd1 << 63);

    localparam logic [DEF_AUX_W-1:0] DEF_AUX_TAPS =
        (411'd1 <<  31) | (411'd1 <<  60) | (411'd1 << 190) |
        (411'd1 << 195) | (411'd1 << 245);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } scr_state_e;

endpackage

// File: rtl/lfsr_scr_step.sv
// One combinational bit-step of the data/aux LFSR pair.
// The data register is fed from the aux MSB sampled before the aux register moves.
module lfsr_scr_step
    import lfsr_scr_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                AUX_W     = DEF_AUX_W,
    parameter logic [DATA_W-1:0] DATA_TAPS = DATA_W'(DEF_DATA_TAPS),
    parameter logic [AUX_W-1:0]  AUX_TAPS  = AUX_W'(DEF_AUX_TAPS)
) (
    input  logic [DATA_W-1:0] d,
    input  logic [AUX_W-1:0]  a,
    input  logic              s,
    output logic [DATA_W-1:0] d_next,
    output logic [AUX_W-1:0]  a_next
);

    logic m_d;
    logic m_a;

    assign m_d = d[DATA_W-1];
    assign m_a = a[AUX_W-1];

    assign d_next = {d[DATA_W-2:0], m_a}
                  ^ ({DATA_W{m_d}} & {DATA_TAPS[DATA_W-1:1], 1'b0});

    assign a_next = {a[AUX_W-2:0], m_a ^ s}
                  ^ ({AUX_W{m_a}} & {AUX_TAPS[AUX_W-1:1], 1'b0});

endmodule

// File: rtl/lfsr_scrambler_par.sv
// Registered dual-LFSR scrambler advancing STEPS bit-steps per accepted word.
// Define LFSR_SCR_ZERO_LOCK_EN to reject all-zero seed loads and flag them on err_zero_seed.
module lfsr_scrambler_par
    import lfsr_scr_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] DATA_TAPS  = DATA_W'(DEF_DATA_TAPS),
    parameter int                AUX_W      = DEF_AUX_W,
    parameter logic [AUX_W-1:0]  AUX_TAPS   = AUX_W'(DEF_AUX_TAPS),
    parameter int                STEPS      = DEF_STEPS,
    parameter int                MAX_BLOCKS = 0,
    parameter int                CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic [AUX_W-1:0]  load_aux,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STEPS-1:0]  serial_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  block_cnt,
    output logic              done,
    output logic              err_zero_seed
);

    localparam bit               LIMIT_EN = (MAX_BLOCKS != 0);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BLOCKS);

    scr_state_e        state_q;
    scr_state_e        state_d;
    logic [DATA_W-1:0] d_q;
    logic [AUX_W-1:0]  a_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              load_ok;
    logic              accept;

    logic [DATA_W-1:0] d_chain [STEPS+1];
    logic [AUX_W-1:0]  a_chain [STEPS+1];

    assign d_chain[0] = d_q;
    assign a_chain[0] = a_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_scr_step #(
            .DATA_W    (DATA_W),
            .AUX_W     (AUX_W),
            .DATA_TAPS (DATA_TAPS),
            .AUX_TAPS  (AUX_TAPS)
        ) u_step (
            .d      (d_chain[g]),
            .a      (a_chain[g]),
            .s      (serial_in[g]),
            .d_next (d_chain[g+1]),
            .a_next (a_chain[g+1])
        );
    end

`ifdef LFSR_SCR_ZERO_LOCK_EN
    logic zero_seed;

    assign zero_seed = load_valid && (load_data == '0) && (load_aux == '0);
    assign load_ok   = load_valid && !zero_seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_zero_seed <= 1'b0;
        end else begin
            err_zero_seed <= zero_seed;
        end
    end
`else
    assign load_ok       = load_valid;
    assign err_zero_seed = 1'b0;
`endif

    // A pending load blocks acceptance even when the load itself is rejected.
    assign in_ready = (state_q == ST_RUN) && !load_valid && (!out_valid || out_ready);
    assign done     = (state_q == ST_DONE);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (block_cnt == '1) ? block_cnt : block_cnt + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_ok) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load_ok) begin
                    state_d = ST_RUN;
                end else if (accept && LIMIT_EN && (cnt_inc == MAX_CNT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load_ok) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load wins over acceptance; acceptance wins over a plain drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q       <= '0;
            a_q       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            block_cnt <= '0;
        end else if (load_ok) begin
            d_q       <= load_data;
            a_q       <= load_aux;
            out_valid <= 1'b0;
            block_cnt <= '0;
        end else if (accept) begin
            d_q       <= d_chain[STEPS];
            a_q       <= a_chain[STEPS];
            data_out  <= d_chain[STEPS];
            out_valid <= 1'b1;
            block_cnt <= cnt_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Directed self-checking bench for lfsr_scrambler_par (default, STEPS=1 and MAX_BLOCKS=3 builds).
// Zero-seed expectations follow LFSR_SCR_ZERO_LOCK_EN.
module tb_lfsr_scrambler_par;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default build (STEPS = 7, unlimited)
    logic         m_load_valid, m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_done, m_err;
    logic [63:0]  m_load_data, m_data_out;
    logic [410:0] m_load_aux;
    logic [6:0]   m_serial_in;
    logic [15:0]  m_block_cnt;

    // Single-step build
    logic         s_load_valid, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_done, s_err;
    logic [63:0]  s_load_data, s_data_out;
    logic [410:0] s_load_aux;
    logic [0:0]   s_serial_in;
    logic [15:0]  s_block_cnt;

    // Block-limited build
    logic         l_load_valid, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_done, l_err;
    logic [63:0]  l_load_data, l_data_out;
    logic [410:0] l_load_aux;
    logic [6:0]   l_serial_in;
    logic [15:0]  l_block_cnt;

    lfsr_scrambler_par u_main (
        .clk(clk), .rst(rst), .load_valid(m_load_valid), .load_data(m_load_data),
        .load_aux(m_load_aux), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .serial_in(m_serial_in), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .data_out(m_data_out), .block_cnt(m_block_cnt), .done(m_done), .err_zero_seed(m_err)
    );

    lfsr_scrambler_par #(.STEPS(1)) u_s1 (
        .clk(clk), .rst(rst), .load_valid(s_load_valid), .load_data(s_load_data),
        .load_aux(s_load_aux), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .serial_in(s_serial_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .data_out(s_data_out), .block_cnt(s_block_cnt), .done(s_done), .err_zero_seed(s_err)
    );

    lfsr_scrambler_par #(.MAX_BLOCKS(3)) u_lim (
        .clk(clk), .rst(rst), .load_valid(l_load_valid), .load_data(l_load_data),
        .load_aux(l_load_aux), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .serial_in(l_serial_in), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .data_out(l_data_out), .block_cnt(l_block_cnt), .done(l_done), .err_zero_seed(l_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [63:0] ld, input logic [410:0] la,
                                 input logic iv, input logic [6:0] si, input logic ordy);
        m_load_valid = lv;
        m_load_data  = ld;
        m_load_aux   = la;
        m_in_valid   = iv;
        m_serial_in  = si;
        m_out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        s_load_valid = 1'b0; s_load_data = '0; s_load_aux = '0;
        s_in_valid = 1'b0; s_serial_in = '0; s_out_ready = 1'b1;
        l_load_valid = 1'b0; l_load_data = '0; l_load_aux = '0;
        l_in_valid = 1'b0; l_serial_in = '0; l_out_ready = 1'b1;

        #2 rst = 1'b0;
        #1;
        checkOutput("rst_data_out", m_data_out, 64'h0);
        checkOutput("rst_out_valid", {63'b0, m_out_valid}, 64'h0);
        checkOutput("rst_in_ready", {63'b0, m_in_ready}, 64'h0);
        checkOutput("rst_block_cnt", {48'b0, m_block_cnt}, 64'h0);
        checkOutput("rst_done", {63'b0, m_done}, 64'h0);
        checkOutput("rst_err", {63'b0, m_err}, 64'h0);
        tick();
        rst = 1'b1;

        // Unseeded block never accepts
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        tick();
        checkOutput("idle_in_ready", {63'b0, m_in_ready}, 64'h0);

        // Load with a coincident word: word must be refused
        applyStimulus(1'b1, 64'h1, '0, 1'b1, 7'h00, 1'b1);
        #1;
        checkOutput("load_blocks_ready", {63'b0, m_in_ready}, 64'h0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        #1;
        checkOutput("ready_after_load", {63'b0, m_in_ready}, 64'h1);
        checkOutput("cnt_after_load", {48'b0, m_block_cnt}, 64'h0);
        tick();
        checkOutput("w1_out_valid", {63'b0, m_out_valid}, 64'h1);
        checkOutput("w1_data_out", m_data_out, 64'h80);
        checkOutput("w1_block_cnt", {48'b0, m_block_cnt}, 64'h1);

        // Simultaneous drain and accept; nonzero serial bits only reach aux low bits
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h5A, 1'b1);
        tick();
        checkOutput("w2_out_valid", {63'b0, m_out_valid}, 64'h1);
        checkOutput("w2_data_out", m_data_out, 64'h4000);
        checkOutput("w2_block_cnt", {48'b0, m_block_cnt}, 64'h2);

        // Back-pressure for 10 cycles
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("bp_in_ready", {63'b0, m_in_ready}, 64'h0);
            checkOutput("bp_data_stable", m_data_out, 64'h4000);
            tick();
        end
        m_out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {63'b0, m_in_ready}, 64'h1);
        tick();
        checkOutput("w3_data_out", m_data_out, 64'h200000);
        checkOutput("w3_block_cnt", {48'b0, m_block_cnt}, 64'h3);
        checkOutput("w3_out_valid", {63'b0, m_out_valid}, 64'h1);
        applyStimulus(1'b0, '0, '0, 1'b0, 7'h00, 1'b1);
        tick();
        checkOutput("drain_out_valid", {63'b0, m_out_valid}, 64'h0);

        // All-zero seed load while running
        applyStimulus(1'b1, '0, '0, 1'b0, 7'h00, 1'b1);
        tick();
`ifdef LFSR_SCR_ZERO_LOCK_EN
        checkOutput("zero_err_pulse", {63'b0, m_err}, 64'h1);
        checkOutput("zero_cnt_kept", {48'b0, m_block_cnt}, 64'h3);
`else
        checkOutput("zero_err_tied", {63'b0, m_err}, 64'h0);
        checkOutput("zero_cnt_clear", {48'b0, m_block_cnt}, 64'h0);
`endif
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        tick();
        checkOutput("zero_err_after", {63'b0, m_err}, 64'h0);
`ifdef LFSR_SCR_ZERO_LOCK_EN
        checkOutput("zero_w_data", m_data_out, 64'h1000_0000);
        checkOutput("zero_w_cnt", {48'b0, m_block_cnt}, 64'h4);
`else
        checkOutput("zero_w_data", m_data_out, 64'h0);
        checkOutput("zero_w_cnt", {48'b0, m_block_cnt}, 64'h1);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, 7'h00, 1'b1);

        // Single-step build: aux MSB feeds data bit 0, then data shifts
        s_load_valid = 1'b1;
        s_load_aux[410] = 1'b1;
        tick();
        s_load_valid = 1'b0;
        s_in_valid = 1'b1;
        tick();
        checkOutput("s1_first_step", s_data_out, 64'h1);
        tick();
        checkOutput("s1_second_step", s_data_out, 64'h2);
        s_in_valid = 1'b0;
        s_load_valid = 1'b1;
        s_load_data = 64'h8000_0000_0000_0000;
        s_load_aux = '0;
        tick();
        s_load_valid = 1'b0;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        checkOutput("s1_tap_mask", s_data_out, 64'hC96C_5795_D787_0F42);

        // Block limit of 3: offer 5 words back to back
        l_load_valid = 1'b1;
        l_load_data = 64'h1;
        tick();
        l_load_valid = 1'b0;
        l_in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (l_in_ready) acc++;
            tick();
        end
        l_in_valid = 1'b0;
        checkOutput("lim_accepted", 64'(acc), 64'h3);
        checkOutput("lim_done", {63'b0, l_done}, 64'h1);
        checkOutput("lim_in_ready", {63'b0, l_in_ready}, 64'h0);
        checkOutput("lim_block_cnt", {48'b0, l_block_cnt}, 64'h3);
        checkOutput("lim_data_out", l_data_out, 64'h200000);
        l_load_valid = 1'b1;
        l_load_data = 64'h5;
        tick();
        l_load_valid = 1'b0;
        #1;
        checkOutput("lim_reload_done", {63'b0, l_done}, 64'h0);
        checkOutput("lim_reload_cnt", {48'b0, l_block_cnt}, 64'h0);
        checkOutput("lim_reload_ready", {63'b0, l_in_ready}, 64'h1);

        // Asynchronous reset with a pending output word
        applyStimulus(1'b1, 64'h1, '0, 1'b0, 7'h00, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b0);
        tick();
        m_in_valid = 1'b0;
        checkOutput("pre_rst_out_valid", {63'b0, m_out_valid}, 64'h1);
        checkOutput("pre_rst_data_out", m_data_out, 64'h80);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", {63'b0, m_out_valid}, 64'h0);
        checkOutput("mid_rst_data_out", m_data_out, 64'h0);
        checkOutput("mid_rst_in_ready", {63'b0, m_in_ready}, 64'h0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_in_ready", {63'b0, m_in_ready}, 64'h0);
        end
        applyStimulus(1'b1, 64'h3, '0, 1'b0, 7'h00, 1'b1);
        tick();
        m_load_valid = 1'b0;
        #1;
        checkOutput("post_rst_reload_ready", {63'b0, m_in_ready}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
